// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Shares one slave bus between the instruction-fetch master (m0)
//               and the data master (m1). A round-robin arbiter picks a
//               request, which is decoded against the system address map.
//               The request is then presented to the slaves with a one-hot
//               select. The slave response is routed back to the granted
//               master. Unmapped addresses get a one-cycle error response
//               and never reach a slave.
// Ports       : clock, reset (sync, active low)
//               m0_*/m1_* : valid/instr/addr/wdata/wstrb in,
//                           rdata/ready/error out
//               s_*       : valid/sel/instr/addr/wdata/wstrb out,
//                           rdata/ready in
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
    parameter logic [31:0] ROM_MASK     = 32'h0000_00FF,
    parameter logic [31:0] SPI_BASE     = 32'h0010_0000,
    parameter logic [31:0] SPI_MASK     = 32'h000F_FFFF,
    parameter logic [31:0] UART_TX_BASE = 32'h0100_0000,
    parameter logic [31:0] UART_TX_MASK = 32'h0000_0003,
    parameter logic [31:0] UART_RX_BASE = 32'h0100_0004,
    parameter logic [31:0] UART_RX_MASK = 32'h0000_0003,
    parameter logic [31:0] CLINT_BASE   = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK   = 32'h0000_FFFF,
    parameter logic [31:0] TIM_BASE     = 32'h1000_0000,
    parameter logic [31:0] TIM_MASK     = 32'h000F_FFFF,
    parameter logic [31:0] SRAM_BASE    = 32'h8000_0000,
    parameter logic [31:0] SRAM_MASK    = 32'h000F_FFFF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_error,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_error,

    output logic        s_valid,
    output logic [6:0]  s_sel,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    localparam int c_NREG = 7;

    // Index i of these tables corresponds to s_sel bit i.
    localparam logic [c_NREG-1:0][31:0] c_BASE = {
        SRAM_BASE, TIM_BASE, CLINT_BASE, UART_RX_BASE,
        UART_TX_BASE, SPI_BASE, ROM_BASE
    };
    localparam logic [c_NREG-1:0][31:0] c_MASK = {
        SRAM_MASK, TIM_MASK, CLINT_MASK, UART_RX_MASK,
        UART_TX_MASK, SPI_MASK, ROM_MASK
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t      r_state_q,   w_state_d;
    logic        r_owner_q,   w_owner_d;    // 0 = m0, 1 = m1
    logic        r_last_q,    w_last_d;     // master granted most recently
    logic        r_s_valid_q, w_s_valid_d;
    logic [6:0]  r_s_sel_q,   w_s_sel_d;
    logic        r_s_instr_q, w_s_instr_d;
    logic [31:0] r_s_addr_q,  w_s_addr_d;
    logic [31:0] r_s_wdata_q, w_s_wdata_d;
    logic [3:0]  r_s_wstrb_q, w_s_wstrb_d;

    logic        w_grant_any;
    logic        w_grant_m1;
    logic        w_req_instr;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_wstrb;
    logic [6:0]  w_hit_sel;
    logic        w_done;
    logic        w_err;
    logic [31:0] w_rdata;

    // Round-robin: on contention the master that did not win last time gets
    // the bus. last_grant resets to m0, so m1 wins the first contention.
    assign w_grant_any = m0_valid | m1_valid;
    assign w_grant_m1  = m1_valid & (~m0_valid | ~r_last_q);

    assign w_req_instr = w_grant_m1 ? m1_instr : m0_instr;
    assign w_req_addr  = w_grant_m1 ? m1_addr  : m0_addr;
    assign w_req_wdata = w_grant_m1 ? m1_wdata : m0_wdata;
    assign w_req_wstrb = w_grant_m1 ? m1_wstrb : m0_wstrb;

    // Scan from the highest index down so that the lowest matching region
    // overwrites any higher one and ends up as the single selected bit.
    always_comb begin
        w_hit_sel = '0;
        for (int i = c_NREG - 1; i >= 0; i--) begin
            if ((w_req_addr & ~c_MASK[i]) == c_BASE[i]) begin
                w_hit_sel    = '0;
                w_hit_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_owner_d   = r_owner_q;
        w_last_d    = r_last_q;
        w_s_valid_d = r_s_valid_q;
        w_s_sel_d   = r_s_sel_q;
        w_s_instr_d = r_s_instr_q;
        w_s_addr_d  = r_s_addr_q;
        w_s_wdata_d = r_s_wdata_q;
        w_s_wstrb_d = r_s_wstrb_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_owner_d   = w_grant_m1;
                    w_last_d    = w_grant_m1;
                    w_s_instr_d = w_req_instr;
                    w_s_addr_d  = w_req_addr;
                    w_s_wdata_d = w_req_wdata;
                    w_s_wstrb_d = w_req_wstrb;
                    if (|w_hit_sel) begin
                        w_state_d   = ST_BUSY;
                        w_s_valid_d = 1'b1;
                        w_s_sel_d   = w_hit_sel;
                    end else begin
                        w_state_d   = ST_ERROR;
                    end
                end
            end
            ST_BUSY: begin
                if (s_ready) begin
                    w_state_d   = ST_IDLE;
                    w_s_valid_d = 1'b0;
                    w_s_sel_d   = '0;
                end
            end
            ST_ERROR: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d   = ST_IDLE;
                w_s_valid_d = 1'b0;
                w_s_sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q   <= ST_IDLE;
            r_owner_q   <= 1'b0;
            r_last_q    <= 1'b0;
            r_s_valid_q <= 1'b0;
            r_s_sel_q   <= '0;
            r_s_instr_q <= 1'b0;
            r_s_addr_q  <= '0;
            r_s_wdata_q <= '0;
            r_s_wstrb_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_owner_q   <= w_owner_d;
            r_last_q    <= w_last_d;
            r_s_valid_q <= w_s_valid_d;
            r_s_sel_q   <= w_s_sel_d;
            r_s_instr_q <= w_s_instr_d;
            r_s_addr_q  <= w_s_addr_d;
            r_s_wdata_q <= w_s_wdata_d;
            r_s_wstrb_q <= w_s_wstrb_d;
        end
    end

    // Master responses are combinational so a zero-wait slave completes in
    // the same cycle it is selected. They are held off while reset is
    // asserted, because an access being abandoned must not complete.
    assign w_done  = reset & (((r_state_q == ST_BUSY) & s_ready) | (r_state_q == ST_ERROR));
    assign w_err   = reset & (r_state_q == ST_ERROR);
    assign w_rdata = (reset & (r_state_q == ST_BUSY) & s_ready) ? s_rdata : '0;

    assign m0_ready = w_done & ~r_owner_q;
    assign m0_error = w_err  & ~r_owner_q;
    assign m0_rdata = r_owner_q ? '0 : w_rdata;
    assign m1_ready = w_done &  r_owner_q;
    assign m1_error = w_err  &  r_owner_q;
    assign m1_rdata = r_owner_q ? w_rdata : '0;

    assign s_valid = r_s_valid_q;
    assign s_sel   = r_s_sel_q;
    assign s_instr = r_s_instr_q;
    assign s_addr  = r_s_addr_q;
    assign s_wdata = r_s_wdata_q;
    assign s_wstrb = r_s_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. A transaction-level
//               reference model predicts every DUT output each cycle.
//               Directed scenarios are followed by randomized traffic from
//               two masters and a random-latency slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_valid = 1'b0, m0_instr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_wstrb = '0;
    logic [31:0] m0_rdata;
    logic        m0_ready, m0_error;
    logic        m1_valid = 1'b0, m1_instr = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic [31:0] m1_rdata;
    logic        m1_ready, m1_error;
    logic        s_valid, s_instr;
    logic [6:0]  s_sel;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = '0;
    logic        s_ready = 1'b0;

    bus_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m0_ready(m0_ready), .m0_error(m0_error),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .m1_ready(m1_ready), .m1_error(m1_error),
        .s_valid(s_valid), .s_sel(s_sel), .s_instr(s_instr), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Address map as [base, base+size) ranges, in select-bit order.
    longint rbase [7] = '{64'h0, 64'h100000, 64'h1000000, 64'h1000004,
                          64'h2000000, 64'h10000000, 64'h80000000};
    longint rsize [7] = '{64'h100, 64'h100000, 64'h4, 64'h4,
                          64'h10000, 64'h100000, 64'h100000};

    // Reference model: one outstanding transaction at most.
    bit          md_busy  = 1'b0;   // request presented to a slave
    bit          md_err   = 1'b0;   // error response due this cycle
    bit          md_owner = 1'b0;
    bit          md_last  = 1'b0;
    int          md_region = 0;
    logic        md_instr = 1'b0;
    logic [31:0] md_addr = '0, md_wdata = '0;
    logic [3:0]  md_wstrb = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        longint la = {32'h0, a};
        for (int i = 0; i < 7; i++)
            if (la >= rbase[i] && la < rbase[i] + rsize[i]) return i;
        return -1;
    endfunction

    function automatic bit exp_done(input bit who);
        return reset && (md_owner == who) && ((md_busy && s_ready) || md_err);
    endfunction

    // Advance the model across a rising edge using the inputs seen at it,
    // then retire any master whose request completed in the cycle just ended.
    task automatic tick();
        bit   r0, r1, g;
        int   reg_i;
        @(posedge clock);
        #1;
        r0 = exp_done(1'b0);
        r1 = exp_done(1'b1);
        if (!reset) begin
            md_busy = 0; md_err = 0; md_owner = 0; md_last = 0;
            md_instr = 0; md_addr = '0; md_wdata = '0; md_wstrb = '0;
        end else if (md_err) begin
            md_err = 0;
        end else if (md_busy) begin
            if (s_ready) md_busy = 0;
        end else if (m0_valid || m1_valid) begin
            g = (m0_valid && m1_valid) ? !md_last : m1_valid;
            md_owner = g;
            md_last  = g;
            md_instr = g ? m1_instr : m0_instr;
            md_addr  = g ? m1_addr  : m0_addr;
            md_wdata = g ? m1_wdata : m0_wdata;
            md_wstrb = g ? m1_wstrb : m0_wstrb;
            reg_i = region_of(md_addr);
            if (reg_i >= 0) begin md_busy = 1; md_region = reg_i; end
            else md_err = 1;
        end
        if (r0) m0_valid = 1'b0;
        if (r1) m1_valid = 1'b0;
    endtask

    task automatic check_all();
        logic [6:0]  esel;
        logic [31:0] erd;
        @(negedge clock);
        esel = md_busy ? (7'd1 << md_region) : 7'd0;
        erd  = (reset && md_busy && s_ready) ? s_rdata : 32'h0;
        check_eq("s_valid",  s_valid, md_busy);
        check_eq("s_sel",    s_sel,   esel);
        check_eq("s_instr",  s_instr, md_instr);
        check_eq("s_addr",   s_addr,  md_addr);
        check_eq("s_wdata",  s_wdata, md_wdata);
        check_eq("s_wstrb",  s_wstrb, md_wstrb);
        check_eq("m0_ready", m0_ready, exp_done(1'b0));
        check_eq("m0_error", m0_error, exp_done(1'b0) && md_err);
        check_eq("m0_rdata", m0_rdata, md_owner ? 32'h0 : erd);
        check_eq("m1_ready", m1_ready, exp_done(1'b1));
        check_eq("m1_error", m1_error, exp_done(1'b1) && md_err);
        check_eq("m1_rdata", m1_rdata, md_owner ? erd : 32'h0);
    endtask

    task automatic issue(input bit who, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (who) begin
            m1_valid = 1'b1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_valid = 1'b1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 6));
        int k = int'($urandom_range(0, 3));
        case (k)
            0:       return $urandom;
            1:       return 32'(rbase[r] + ({32'h0, $urandom} % rsize[r]));
            2:       return 32'(rbase[r] + rsize[r] - 1);
            default: return 32'(rbase[r] + rsize[r]);
        endcase
    endfunction

    initial begin
        int          seq_idx;
        int          pulses;
        logic [31:0] b_addr [5];
        logic [6:0]  b_sel  [5];
        b_addr = '{32'h000000FF, 32'h00000100, 32'h001FFFFF, 32'h100FFFFF, 32'h10100000};
        b_sel  = '{7'h01, 7'h00, 7'h02, 7'h20, 7'h00};

        // Reset state
        tick(); check_all();
        tick(); check_all();
        check_eq("rst_s_valid", s_valid, 1'b0);
        check_eq("rst_s_sel",   s_sel,   7'h00);

        // m1 read of the uart rx register, zero-wait slave
        tick(); reset = 1'b1; issue(1'b1, 1'b0, 32'h01000004, 32'h0, 4'h0); check_all();
        tick(); s_ready = 1'b1; s_rdata = 32'hA5; check_all();
        check_eq("uart_sel",   s_sel,    7'b0001000);
        check_eq("uart_rdy",   m1_ready, 1'b1);
        check_eq("uart_rdata", m1_rdata, 32'hA5);
        check_eq("uart_err",   m1_error, 1'b0);
        tick(); s_ready = 1'b0; check_all();

        // Contention straight out of reset: m1 first, then alternate
        tick(); reset = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; check_all();
        tick(); reset = 1'b1; s_ready = 1'b1;
        issue(1'b0, 1'b1, 32'h00000010, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 32'h80000000, 32'h0, 4'h0);
        check_all();
        seq_idx = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (!m0_valid) issue(1'b0, 1'b1, 32'h00000010 + 32'(c * 4), 32'h0, 4'h0);
            if (!m1_valid) issue(1'b1, 1'b0, 32'h80000000 + 32'(c * 4), 32'h0, 4'h0);
            s_rdata = $urandom;
            check_all();
            if (m0_ready || m1_ready) begin
                check_eq("rr_order", m1_ready, (seq_idx % 2) == 0);
                seq_idx++;
            end
        end
        check_eq("rr_count", seq_idx, 6);
        tick(); m0_valid = 1'b0; m1_valid = 1'b0; check_all();
        tick(); check_all();
        tick(); s_ready = 1'b0; check_all();

        // m1 write to sram with three wait states
        tick(); issue(1'b1, 1'b0, 32'h80000010, 32'h1234, 4'b0011); check_all();
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); s_ready = (k == 3); check_all();
            check_eq("ws_addr",  s_addr,  32'h80000010);
            check_eq("ws_wstrb", s_wstrb, 4'b0011);
            check_eq("ws_sel",   s_sel,   7'b1000000);
            pulses += int'(m1_ready);
        end
        tick(); s_ready = 1'b0; check_all();
        pulses += int'(m1_ready);
        check_eq("ws_pulses", pulses, 1);

        // m0 fetch from an unmapped address
        tick(); issue(1'b0, 1'b1, 32'h00000400, 32'h0, 4'h0); check_all();
        tick(); check_all();
        check_eq("unm_valid", s_valid,  1'b0);
        check_eq("unm_rdy",   m0_ready, 1'b1);
        check_eq("unm_err",   m0_error, 1'b1);

        // Region boundaries
        for (int b = 0; b < 5; b++) begin
            tick(); s_ready = 1'b1; issue(1'b0, 1'b0, b_addr[b], 32'h0, 4'h0); check_all();
            tick(); s_rdata = $urandom; check_all();
            check_eq("bnd_sel", s_sel,    b_sel[b]);
            check_eq("bnd_err", m0_error, b_sel[b] == 7'h00);
        end
        tick(); s_ready = 1'b0; check_all();

        // Reset while waiting on a slave, then a late s_ready
        tick(); issue(1'b0, 1'b0, 32'h80000100, 32'h0, 4'h0); check_all();
        tick(); check_all();
        check_eq("rb_busy", s_valid, 1'b1);
        tick(); reset = 1'b0; m0_valid = 1'b0; check_all();
        check_eq("rb_rdy_in_rst", m0_ready, 1'b0);
        tick(); reset = 1'b1; s_ready = 1'b1; s_rdata = 32'hDEAD; check_all();
        check_eq("rb_valid", s_valid,  1'b0);
        check_eq("rb_late",  m0_ready, 1'b0);
        tick(); s_ready = 1'b0; issue(1'b1, 1'b0, 32'h02000008, 32'h0, 4'h0); check_all();
        tick(); s_ready = 1'b1; s_rdata = 32'h5A5A; check_all();
        check_eq("rb_new_rdy", m1_ready, 1'b1);
        check_eq("rb_new_sel", s_sel,    7'b0010000);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            s_ready = ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            if (!m0_valid) begin
                if ($urandom_range(0, 2) == 0)
                    issue(1'b0, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
            end else if (md_busy && !md_owner && $urandom_range(0, 7) == 0) begin
                m0_valid = 1'b0;
            end
            if (!m1_valid) begin
                if ($urandom_range(0, 2) == 0)
                    issue(1'b1, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
            end else if (md_busy && md_owner && $urandom_range(0, 7) == 0) begin
                m1_valid = 1'b0;
            end
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
